// File: rtl/fpu_regfile_sb_if.sv
// Bus bundle for fpu_regfile_sb: read ports, issue-side scoreboard query,
// write-back ports, flush and scoreboard status.
interface fpu_regfile_sb_if #(
  parameter int FLEN = 32,
  parameter int NREG = 32,
  parameter int NWB  = 2
);
  localparam int AW = $clog2(NREG);

  logic [2:0]          rd_en;
  logic [3*AW-1:0]     rd_addr;
  logic [3*FLEN-1:0]   rd_data;
  logic                iss_valid;
  logic                iss_long;
  logic                iss_wren;
  logic [AW-1:0]       iss_waddr;
  logic                stall;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*AW-1:0]   wb_addr;
  logic [NWB*FLEN-1:0] wb_data;
  logic                flush;
  logic [AW:0]         pend_cnt;
  logic                busy;

  modport master (
    output rd_en, rd_addr, iss_valid, iss_long, iss_wren, iss_waddr,
           wb_valid, wb_addr, wb_data, flush,
    input  rd_data, stall, pend_cnt, busy
  );

  modport slave (
    input  rd_en, rd_addr, iss_valid, iss_long, iss_wren, iss_waddr,
           wb_valid, wb_addr, wb_data, flush,
    output rd_data, stall, pend_cnt, busy
  );
endinterface

// File: rtl/fpu_regfile_sb.sv
// FP register file with long-latency scoreboard and multi-port write-back.
// Optional feature macro: FPU_RF_BYPASS_EN
//   defined   : write-back data is forwarded to the read ports in the same
//               cycle, and a long write-back releases the stall it clears.
//   undefined : reads see array content only; any read that collides with a
//               valid write-back stalls, and a clearing long write-back only
//               releases the stall on the following cycle.
// Port NWB-1 is the long-latency write-back port; only it clears claims.
module fpu_regfile_sb #(
  parameter int FLEN = 32,
  parameter int NREG = 32,
  parameter int NWB  = 2
) (
  input logic             clock,
  input logic             reset,
  fpu_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int LP = NWB - 1;
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [FLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [AW:0]     cnt;

  logic [AW-1:0]   rd_a [3];
  logic [AW-1:0]   wb_a [NWB];
  logic [FLEN-1:0] wb_d [NWB];
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] claim_vec;
  logic            hazard;
  logic            stall_i;
  logic            claim;
  logic            clr_hit;
  logic [3*FLEN-1:0] rd_data_i;

  // unpack the flat address/data buses
  always_comb begin
    for (int k = 0; k < 3; k++) rd_a[k] = bus.rd_addr[k*AW +: AW];
    for (int p = 0; p < NWB; p++) begin
      wb_a[p] = bus.wb_addr[p*AW +: AW];
      wb_d[p] = bus.wb_data[p*FLEN +: FLEN];
    end
  end

  // claims released by the long write-back port this cycle
  always_comb begin
    clr_vec = '0;
    if (bus.wb_valid[LP]) clr_vec[wb_a[LP]] = 1'b1;
  end

  // issue hazard: source or destination still owned by a long op
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bus.rd_en[k]) begin
`ifdef FPU_RF_BYPASS_EN
        if (pend[rd_a[k]] && !clr_vec[rd_a[k]]) hazard = 1'b1;
`else
        if (pend[rd_a[k]]) hazard = 1'b1;
        // without forwarding, a read racing a write-back sees stale data
        for (int p = 0; p < NWB; p++)
          if (bus.wb_valid[p] && (wb_a[p] == rd_a[k])) hazard = 1'b1;
`endif
      end
    end
    if (bus.iss_wren) begin
`ifdef FPU_RF_BYPASS_EN
      if (pend[bus.iss_waddr] && !clr_vec[bus.iss_waddr]) hazard = 1'b1;
`else
      if (pend[bus.iss_waddr]) hazard = 1'b1;
`endif
    end
    stall_i = bus.iss_valid & hazard;
  end

  // new claim and whether the long write-back retires a real claim
  always_comb begin
    claim     = bus.iss_valid & bus.iss_long & bus.iss_wren & ~stall_i & ~bus.flush;
    claim_vec = '0;
    if (claim) claim_vec[bus.iss_waddr] = 1'b1;
    clr_hit   = |(pend & clr_vec);
  end

  // read ports, highest-index matching write-back wins when forwarding
  always_comb begin
    rd_data_i = '0;
    for (int k = 0; k < 3; k++) begin
      if (bus.rd_en[k]) begin
        rd_data_i[k*FLEN +: FLEN] = regs[rd_a[k]];
`ifdef FPU_RF_BYPASS_EN
        for (int p = 0; p < NWB; p++)
          if (bus.wb_valid[p] && (wb_a[p] == rd_a[k]))
            rd_data_i[k*FLEN +: FLEN] = wb_d[p];
`endif
      end
    end
  end

  // register array write, later port overrides on address collision
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWB; p++)
        if (bus.wb_valid[p]) regs[wb_a[p]] <= wb_d[p];
    end
  end

  // scoreboard bits and pending count; a same-address set beats the clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= (pend & ~clr_vec) | claim_vec;
      // claim onto a live claim cannot happen (it stalls), so +1/-1 is exact
      case ({claim, clr_hit})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.stall    = stall_i;
  assign bus.rd_data  = rd_data_i;
  assign bus.pend_cnt = cnt;
  assign bus.busy     = (cnt != '0);
endmodule

// File: doc/fpu_regfile_sb.md
# fpu_regfile_sb

Parametrised floating-point register file with an integrated scoreboard and multi-port write-back bypass, replacing the fixed 32x32 register file plus single-stage forwarding pair in the FPU. It tracks destination registers claimed by long-latency operations (fdiv, fsqrt, iterative fma) and raises a stall to the issue stage until their results return. It sits between FP decode/issue and the execute/write-back stages.

## Interface

- FLEN, 32: register width in bits (32 or 64).
- NREG, 32: number of FP registers; AW = $clog2(NREG).
- NWB, 2: write-back ports; port NWB-1 is the long-latency port, ports 0..NWB-2 are pipeline ports.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- rd_en  in  3  read enable per read port (rs1, rs2, rs3).
- rd_addr  in  3*AW  read addresses, port k at [k*AW +: AW].
- rd_data  out  3*FLEN  read data, port k at [k*FLEN +: FLEN]; 0 when rd_en[k]=0.
- iss_valid  in  1  instruction in issue stage.
- iss_long  in  1  issued op is long-latency and claims iss_waddr.
- iss_wren  in  1  issued op writes an FP register.
- iss_waddr  in  AW  destination of issued op.
- stall  out  1  issue must hold this cycle.
- wb_valid  in  NWB  write-back valid per port.
- wb_addr  in  NWB*AW  write-back address per port.
- wb_data  in  NWB*FLEN  write-back data per port.
- flush  in  1  pipeline flush; discards all pending claims.
- pend_cnt  out  AW+1  number of registers currently pending.
- busy  out  1  pend_cnt != 0.

## Operation

- Storage: NREG x FLEN array; all registers are general (no hardwired zero).
- Write: on rising edge, each wb_valid[p] writes wb_data[p] to wb_addr[p]; on address collision the higher port index wins.
- Read: combinational; rd_data[k] = bypassed value (highest-index valid wb port with matching address) if any, else array content.
- Scoreboard: one pending bit per register.
  - Set: iss_valid & iss_long & iss_wren & !stall sets pend[iss_waddr].
  - Clear: wb_valid[NWB-1] clears pend[wb_addr[NWB-1]]; pipeline ports never clear.
  - Same address set and clear in one cycle: set wins (new claim).
  - flush clears all pending bits; flush and a set in the same cycle: set is ignored.
- stall = iss_valid & (any k with rd_en[k] & pend[rd_addr[k]] and not cleared by the same-cycle long write-back, OR iss_wren & pend[iss_waddr] and not cleared the same cycle). A same-cycle clear therefore releases the stall (bypass supplies data).
- pend_cnt: incremented on set, decremented on clear of a set bit, both/neither leave it unchanged; cleared by flush. Never exceeds NREG.
- Long write-back to a non-pending register: data written, pend unchanged, no error.

## Timing

- Reset (reset=0 at edge): all registers 0, all pend 0, pend_cnt 0; outputs then stall=0, busy=0, rd_data=0. Reset mid-operation discards pending claims; later long write-backs still write data.
- Write latency 1 cycle; bypass makes written value visible to reads in the same cycle.
- Pending bit visible to stall one cycle after the claiming issue.
- stall and rd_data purely combinational from inputs and state; no registered outputs except via state.
- Back-to-back claims to different registers each cycle permitted; pend_cnt tracks exactly.

## Configuration

- FPU_RF_BYPASS_EN defined: combinational write-back bypass to read ports as above; same-cycle long clear releases stall.
- Undefined: no bypass; rd_data is array content only. stall additionally asserts when any enabled read address matches any valid write-back address that cycle, and a same-cycle long clear does not release the stall (released next cycle). Scoreboard otherwise identical.

## Test plan

- Reset then read f5 with rd_en=1 -> rd_data=0, stall=0, busy=0, pend_cnt=0.
- wb_valid[0], addr 3, data 0x3F800000; same cycle read f3 -> bypass gives 0x3F800000 (EN defined); without EN stall=1, next cycle read gives 0x3F800000.
- Issue long to f7; next cycle read f7 -> stall=1, pend_cnt=1; long wb to f7 with 0x40490FDB -> same cycle stall=0 and rd_data=0x40490FDB (EN defined); pend_cnt=0 next cycle.
- Long wb clears f4 while new long issue claims f4 same cycle -> pend[f4] remains 1, pend_cnt unchanged.
- Claim f1, f2, f9 consecutively -> pend_cnt=3, busy=1; flush -> pend_cnt=0, busy=0, reads of f1 no longer stall.
- Ports 0 and 1 both write f10 (0x1, 0x2) same cycle -> f10=0x2 after edge; bypass read also returns 0x2.
